// File: rtl/mux_stream_rr.sv
// N-input registered stream multiplexer with valid/ready handshake.
// Selects by explicit index (mode 0) or round-robin among valid inputs (mode 1).
module mux_stream_rr #(
  parameter  int unsigned N_IN  = 4,
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             can_load;
  logic             sel_ok;
  logic             found;
  logic [SEL_W-1:0] gidx;
  logic [SEL_W-1:0] idx;
  logic [N_IN-1:0]  grant;
  logic [WIDTH-1:0] mux_data;

  assign can_load = ~out_valid_q | out_ready;
  assign sel_ok   = ({1'b0, sel} < (SEL_W + 1)'(N_IN));

  // Arbitration: a grant is only ever issued when the output stage can take a word.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    grant = '0;
    if (can_load) begin
      if (!mode) begin
        if (sel_ok && in_valid[sel]) begin
          found = 1'b1;
          gidx  = sel;
        end
      end else begin
        for (int unsigned k = 1; k <= N_IN; k++) begin
          idx = SEL_W'((32'(rr_ptr_q) + k) % N_IN);
          if (!found && in_valid[idx]) begin
            found = 1'b1;
            gidx  = idx;
          end
        end
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign in_ready = grant;

  // AND-OR selection so ungranted channels are gated to zero, never propagated.
  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (found) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_chan_d  = gidx;
      if (mode) rr_ptr_d = gidx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer resets to the last channel so channel 0 wins the first round-robin search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= SEL_W'(N_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Scoreboard bench for mux_stream_rr: directed stimulus pushes expected words,
// a negedge monitor pops and compares every accepted output.
module tb_mux_stream_rr;
  localparam int unsigned N_IN  = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_chan;
  logic                  out_valid;
  logic                  out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [SEL_W-1:0] chan;
    logic [WIDTH-1:0] data;
    bit               chk_data;
  } exp_t;

  exp_t sb[$];

  mux_stream_rr #(.N_IN(N_IN), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ch, input logic [WIDTH-1:0] d, input bit chk);
    exp_t e;
    e.chan     = SEL_W'(ch);
    e.data     = d;
    e.chk_data = chk;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; combinational checks follow 1 unit later.
  task automatic drive(input bit m, input logic [SEL_W-1:0] s, input logic [N_IN-1:0] v,
                       input bit ordy);
    @(posedge clk);
    #1;
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: a word is consumed whenever valid and ready are both high at the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got chan %0d data %0h expected none",
                   out_chan, out_data);
        end else begin
          e = sb.pop_front();
          check("out_chan", 32'(out_chan), 32'(e.chan));
          if (e.chk_data) check("out_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] dat [N_IN];
    int rr_seq [5];
    dat    = '{4'hA, 4'hB, 4'hC, 4'hD};
    rr_seq = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    in_data   = 16'hDCBA;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_out_chan",  32'(out_chan),  32'd0);
    in_valid = 4'h0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed select of channel 2
    drive(1'b0, 2'd2, 4'hF, 1'b1);
    check("m0_in_ready", 32'(in_ready), 32'h4);
    push(2, 4'hC, 1'b1);
    drive(1'b0, 2'd2, 4'h0, 1'b1);

    // Round-robin over all channels
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 4'hF, 1'b1);
      check("rr_in_ready", 32'(in_ready), 32'd1 << rr_seq[i]);
      push(rr_seq[i], dat[rr_seq[i]], 1'b1);
    end
    drive(1'b1, 2'd0, 4'h0, 1'b1);

    // Sparse valid: only channels 1 and 3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 4'b1010, 1'b1);
      check("sparse_in_ready", 32'(in_ready), (i == 1) ? 32'h8 : 32'h2);
      push((i == 1) ? 3 : 1, (i == 1) ? 4'hD : 4'hB, 1'b1);
    end
    drive(1'b1, 2'd0, 4'h0, 1'b1);

    // Backpressure: pointer is at 1, so channel 2 loads, stalls, then channel 3 follows
    drive(1'b1, 2'd0, 4'hF, 1'b1);
    check("bp_first_in_ready", 32'(in_ready), 32'h4);
    push(2, 4'hC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 4'hF, 1'b0);
      check("bp_in_ready",  32'(in_ready),  32'h0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'hC);
      check("bp_out_chan",  32'(out_chan),  32'd2);
    end
    drive(1'b1, 2'd0, 4'hF, 1'b1);
    check("bp_resume_in_ready", 32'(in_ready), 32'h8);
    push(3, 4'hD, 1'b1);
    drive(1'b1, 2'd0, 4'h0, 1'b1);

    // X on channel 3 must not leak into channels 0..2
    in_data = {4'bxxxx, 4'd3, 4'd10, 4'd7};
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, SEL_W'(s), 4'hF, 1'b1);
      check("x_in_ready", 32'(in_ready), 32'd1 << s);
      case (s)
        0:       push(0, 4'd7,  1'b1);
        1:       push(1, 4'd10, 1'b1);
        2:       push(2, 4'd3,  1'b1);
        default: push(3, 4'd0,  1'b0);
      endcase
    end
    drive(1'b0, 2'd0, 4'h0, 1'b1);
    drain();

    // Reset mid-cycle while a word is held; pointer moved to 0 and must return to 3
    in_data = 16'hDCBA;
    drive(1'b1, 2'd0, 4'hF, 1'b0);
    check("pre_reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data",  32'(out_data),  32'd0);
    check("midreset_out_chan",  32'(out_chan),  32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'h1);
    push(0, 4'hA, 1'b1);
    drive(1'b1, 2'd0, 4'h0, 1'b1);
    drain();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
